gmii_rx_dispatch: RTL

GMII_RX_DISPATCH -- requirements
Module: gmii_rx_dispatch

---
 rtl/eth_rx_pkg.sv | 24 ++
 rtl/gmii_rx_dispatch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and Ethernet constants for the GMII receive dispatcher.
package eth_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DST_MAC,
      ST_SRC_MAC,
      ST_ETHTYPE,
      ST_PAYLOAD,
      ST_DISCARD
   } rx_state_t;

   localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
   localparam logic [7:0]  ETH_SFD       = 8'hD5;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
   localparam logic [47:0] ETH_BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

   // Preamble bytes required before the SFD; last index of a 6-byte MAC.
   localparam logic [2:0]  PREAMBLE_LEN  = 3'd7;
   localparam logic [2:0]  MAC_LAST      = 3'd5;

endpackage

// File: rtl/gmii_rx_dispatch.sv
// GMII receive header parser: filters on destination MAC and ethertype and
// forwards the remaining bytes (FCS included) to the ARP or IP/UDP sink.
module gmii_rx_dispatch
   import eth_rx_pkg::*;
#(
   parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55
) (
   input  logic        i_gmii_rx_clk,
   input  logic        i_sys_rst,
   input  logic        i_gmii_rx_dv,
   input  logic [7:0]  i_gmii_rx_data,
   output logic [7:0]  o_pay_data,
   output logic        o_arp_dv,
   output logic        o_ip_dv,
   output logic        o_pay_sof,
   output logic        o_pay_eof,
   output logic [15:0] o_pay_len,
   output logic [47:0] o_src_mac,
   output logic        o_frame_drop,
   output logic        o_rx_busy
);

   rx_state_t   state, state_nxt;
   logic [2:0]  hdr_cnt, hdr_cnt_nxt;
   logic [39:0] dst_shift;
   logic [47:0] src_shift;
   logic [7:0]  type_hi;
   logic        sel_arp;
   logic [7:0]  pend_data;
   logic        pend_vld;
   logic        pend_sof;
   logic [15:0] pay_cnt;
   logic        drop;
   logic        capture;
   logic        emit;
   logic        accept;
   logic [47:0] dst_full;
   logic [15:0] type_full;

   assign dst_full  = {dst_shift, i_gmii_rx_data};
   assign type_full = {type_hi, i_gmii_rx_data};

   always_ff @(posedge i_gmii_rx_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state   <= ST_IDLE;
         hdr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         hdr_cnt <= hdr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      hdr_cnt_nxt = hdr_cnt;
      drop        = 1'b0;
      capture     = 1'b0;
      emit        = 1'b0;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            hdr_cnt_nxt = '0;
            if (i_gmii_rx_dv) begin
               if (i_gmii_rx_data == ETH_PREAMBLE) begin
                  state_nxt   = ST_PREAMBLE;
                  hdr_cnt_nxt = 3'd1;
               end else begin
                  state_nxt = ST_DISCARD;
                  drop      = 1'b1;
               end
            end
         end
         ST_PREAMBLE: begin
            if (!i_gmii_rx_dv) begin
               state_nxt = ST_IDLE;
               drop      = 1'b1;
            end else if (i_gmii_rx_data == ETH_PREAMBLE && hdr_cnt < PREAMBLE_LEN) begin
               hdr_cnt_nxt = hdr_cnt + 3'd1;
            end else if (i_gmii_rx_data == ETH_SFD && hdr_cnt == PREAMBLE_LEN) begin
               state_nxt   = ST_DST_MAC;
               hdr_cnt_nxt = '0;
            end else begin
               state_nxt = ST_DISCARD;
               drop      = 1'b1;
            end
         end
         ST_DST_MAC: begin
            if (!i_gmii_rx_dv) begin
               state_nxt = ST_IDLE;
               drop      = 1'b1;
            end else if (hdr_cnt == MAC_LAST) begin
               hdr_cnt_nxt = '0;
               if (dst_full == BOARD_MAC || dst_full == ETH_BCAST_MAC) begin
                  state_nxt = ST_SRC_MAC;
               end else begin
                  state_nxt = ST_DISCARD;
                  drop      = 1'b1;
               end
            end else begin
               hdr_cnt_nxt = hdr_cnt + 3'd1;
            end
         end
         ST_SRC_MAC: begin
            if (!i_gmii_rx_dv) begin
               state_nxt = ST_IDLE;
               drop      = 1'b1;
            end else if (hdr_cnt == MAC_LAST) begin
               state_nxt   = ST_ETHTYPE;
               hdr_cnt_nxt = '0;
            end else begin
               hdr_cnt_nxt = hdr_cnt + 3'd1;
            end
         end
         ST_ETHTYPE: begin
            if (!i_gmii_rx_dv) begin
               state_nxt = ST_IDLE;
               drop      = 1'b1;
            end else if (hdr_cnt == 3'd1) begin
               hdr_cnt_nxt = '0;
               if (type_full == ETH_TYPE_ARP || type_full == ETH_TYPE_IP) begin
                  state_nxt = ST_PAYLOAD;
                  accept    = 1'b1;
               end else begin
                  state_nxt = ST_DISCARD;
                  drop      = 1'b1;
               end
            end else begin
               hdr_cnt_nxt = hdr_cnt + 3'd1;
            end
         end
         ST_PAYLOAD: begin
            // One byte is held back so eof can ride on the last byte.
            if (i_gmii_rx_dv) begin
               capture = 1'b1;
               emit    = pend_vld;
            end else begin
               state_nxt = ST_IDLE;
               emit      = pend_vld;
               drop      = ~pend_vld;
            end
         end
         ST_DISCARD: begin
            if (!i_gmii_rx_dv) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_gmii_rx_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         dst_shift    <= '0;
         src_shift    <= '0;
         type_hi      <= '0;
         sel_arp      <= 1'b0;
         pend_data    <= '0;
         pend_vld     <= 1'b0;
         pend_sof     <= 1'b0;
         pay_cnt      <= '0;
         o_pay_data   <= '0;
         o_arp_dv     <= 1'b0;
         o_ip_dv      <= 1'b0;
         o_pay_sof    <= 1'b0;
         o_pay_eof    <= 1'b0;
         o_pay_len    <= '0;
         o_src_mac    <= '0;
         o_frame_drop <= 1'b0;
         o_rx_busy    <= 1'b0;
      end else begin
         if (i_gmii_rx_dv) begin
            case (state)
               ST_DST_MAC: dst_shift <= {dst_shift[31:0], i_gmii_rx_data};
               ST_SRC_MAC: src_shift <= {src_shift[39:0], i_gmii_rx_data};
               ST_ETHTYPE: if (hdr_cnt == 3'd0) type_hi <= i_gmii_rx_data;
               default: ;
            endcase
         end
         if (accept) begin
            o_src_mac <= src_shift;
            sel_arp   <= (type_full == ETH_TYPE_ARP);
            pay_cnt   <= '0;
         end
         if (capture) begin
            pend_data <= i_gmii_rx_data;
            pend_sof  <= ~pend_vld;
            if (pay_cnt != 16'hFFFF) pay_cnt <= pay_cnt + 16'd1;
         end
         pend_vld     <= capture;
         if (emit) o_pay_data <= pend_data;
         if (emit && !i_gmii_rx_dv) o_pay_len <= pay_cnt;
         o_arp_dv     <= emit & sel_arp;
         o_ip_dv      <= emit & ~sel_arp;
         o_pay_sof    <= emit & pend_sof;
         o_pay_eof    <= emit & ~i_gmii_rx_dv;
         o_frame_drop <= drop;
         o_rx_busy    <= (state_nxt != ST_IDLE);
      end
   end

endmodule
